// File: rtl/fp_conv_pkg.sv
// Shared definitions for the float-to-fixed converter.
// Holds the controller state encoding, IEEE-754 field-size helpers and the
// 64-bit saturation patterns that the top level narrows to its output width.
package fp_conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_UNPACK = 3'd1,
    ST_ALIGN  = 3'd2,
    ST_ROUND  = 3'd3,
    ST_PACK   = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  // Most-positive / most-negative two's-complement patterns at 64 bits;
  // shifting right by (64-W) yields the W-bit limits.
  localparam logic [63:0] SAT_POS_64 = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] SAT_NEG_64 = 64'h8000_0000_0000_0000;

  function automatic int exp_bits(input int p);
    return (p == 64) ? 11 : 8;
  endfunction

  function automatic int man_bits(input int p);
    return (p == 64) ? 52 : 23;
  endfunction

  function automatic int bias(input int p);
    return (p == 64) ? 1023 : 127;
  endfunction

endpackage

// File: rtl/fp_align_shift.sv
// Combinational signed-amount barrel shifter for the float-to-fixed converter.
// Ports:
//   sig    : significand {1,m} (MW+1 bits), zero for zero/subnormal/special
//   sh     : signed shift amount, positive = left
//   mag    : aligned integer magnitude (W+1 bits)
//   guard  : first bit below the binary point after a right shift
//   sticky : OR of every bit below the guard bit
//   ovf    : magnitude does not fit in W+1 bits
module fp_align_shift
  import fp_conv_pkg::*;
#(
  parameter  int P  = 32,
  parameter  int W  = 32,
  localparam int EW = exp_bits(P),
  localparam int MW = man_bits(P)
) (
  input  logic [MW:0]          sig,
  input  logic signed [EW+1:0] sh,
  output logic [W:0]           mag,
  output logic                 guard,
  output logic                 sticky,
  output logic                 ovf
);

  localparam int SW = EW + 2;
  localparam int LW = MW + W + 2;                 // left-shift workspace
  localparam int RW = 2 * MW + 3;                 // sig plus MW+2 bits of fraction room
  localparam int XW = (MW > W) ? MW + 1 : W + 1;  // integer part of a right shift
  localparam logic signed [SW-1:0] W_S   = SW'(W);
  localparam logic        [SW-1:0] MAX_R = SW'(MW + 2);

  logic [SW-1:0] amt_l;
  logic [SW-1:0] amt_r;
  logic [LW-1:0] wide_l;
  logic [RW-1:0] wide_r;
  logic [XW-1:0] int_r;

  always_comb begin
    amt_l  = sh;
    amt_r  = -sh;
    wide_l = {{(W+1){1'b0}}, sig} << amt_l;
    wide_r = {sig, {(MW+2){1'b0}}} >> amt_r;
    int_r  = XW'(wide_r[RW-1:MW+2]);
    mag    = '0;
    guard  = 1'b0;
    sticky = 1'b0;
    ovf    = 1'b0;
    if (!sh[SW-1]) begin
      mag = wide_l[W:0];
      ovf = (sh > W_S) || (wide_l[LW-1:W+1] != '0);
    end else if (amt_r > MAX_R) begin
      // Everything falls below the guard position.
      sticky = |sig;
    end else begin
      mag    = int_r[W:0];
      guard  = wide_r[MW+1];
      sticky = |wide_r[MW:0];
      // A narrow output can still be exceeded by a right-shifted double.
      ovf    = (int_r >> (W+1)) != '0;
    end
  end

endmodule

// File: rtl/float_to_fixed_conv.sv
// IEEE-754 (single or double) to signed fixed-point converter with a
// Begin/ACK level handshake.
// Ports:
//   CLK, RST  : clock, synchronous active-high reset
//   Begin_FSM : start request, level-sampled in IDLE
//   T, RND    : float operand and rounding mode (1 = nearest-even), captured on accept
//   ACK       : result valid, held while Begin_FSM stays high
//   O_F, U_F  : overflow/saturation/NaN/Inf flag, underflow flag
//   RESULT    : W-bit two's-complement result with FRAC fraction bits
module float_to_fixed_conv
  import fp_conv_pkg::*;
#(
  parameter int P    = 32,
  parameter int W    = 32,
  parameter int FRAC = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         Begin_FSM,
  input  logic [P-1:0] T,
  input  logic         RND,
  output logic         ACK,
  output logic         O_F,
  output logic         U_F,
  output logic [W-1:0] RESULT
);

  localparam int EW   = exp_bits(P);
  localparam int MW   = man_bits(P);
  localparam int BIAS = bias(P);
  localparam int SW   = EW + 2;
  localparam logic signed [SW-1:0] SH_OFS = SW'(FRAC - MW - BIAS);
  localparam logic [63:0]  POS_SH  = SAT_POS_64 >> (64 - W);
  localparam logic [63:0]  NEG_SH  = SAT_NEG_64 >> (64 - W);
  localparam logic [W-1:0] SAT_POS = POS_SH[W-1:0];
  localparam logic [W-1:0] SAT_NEG = NEG_SH[W-1:0];

  state_t state_q, state_d;
  logic [P-1:0]         t_q, t_d;
  logic                 rnd_q, rnd_d;
  logic                 s_q, s_d;
  logic                 nz_q, nz_d;
  logic                 nan_q, nan_d;
  logic                 inf_q, inf_d;
  logic [MW:0]          sig_q, sig_d;
  logic signed [SW-1:0] sh_q, sh_d;
  logic [W+1:0]         mag_q, mag_d;
  logic                 grd_q, grd_d;
  logic                 stk_q, stk_d;
  logic                 ovf_q, ovf_d;
  logic [W-1:0]         res_q, res_d;
  logic                 of_q, of_d;
  logic                 uf_q, uf_d;
  logic                 ack_q, ack_d;

  logic [EW-1:0] e_u;
  logic [MW-1:0] m_u;
  logic [W:0]    al_mag;
  logic          al_grd, al_stk, al_ovf;

  assign e_u = t_q[P-2:MW];
  assign m_u = t_q[MW-1:0];

  fp_align_shift #(.P(P), .W(W)) u_align (
    .sig    (sig_q),
    .sh     (sh_q),
    .mag    (al_mag),
    .guard  (al_grd),
    .sticky (al_stk),
    .ovf    (al_ovf)
  );

  // One extra bit so a round-up of an all-ones magnitude is not lost.
  function automatic logic [W+1:0] round_mag(input logic [W:0] mag, input logic grd,
                                             input logic stk, input logic rne);
    logic inc;
    inc = rne & grd & (stk | mag[0]);
    return {1'b0, mag} + {{(W+1){1'b0}}, inc};
  endfunction

  // Returns {overflow, result}; the negative side may reach 2^(W-1).
  function automatic logic [W:0] sat_pack(input logic s, input logic [W+1:0] mag,
                                          input logic force_sat);
    logic [W+1:0] lim;
    lim = s ? {2'b00, SAT_NEG} : {2'b00, SAT_POS};
    if (force_sat || (mag > lim)) return {1'b1, s ? SAT_NEG : SAT_POS};
    return {1'b0, s ? ({W{1'b0}} - mag[W-1:0]) : mag[W-1:0]};
  endfunction

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    rnd_d   = rnd_q;
    s_d     = s_q;
    nz_d    = nz_q;
    nan_d   = nan_q;
    inf_d   = inf_q;
    sig_d   = sig_q;
    sh_d    = sh_q;
    mag_d   = mag_q;
    grd_d   = grd_q;
    stk_d   = stk_q;
    ovf_d   = ovf_q;
    res_d   = res_q;
    of_d    = of_q;
    uf_d    = uf_q;
    ack_d   = ack_q;
    case (state_q)
      ST_IDLE: begin
        if (Begin_FSM) begin
          t_d     = T;
          rnd_d   = RND;
          state_d = ST_UNPACK;
        end
      end
      // Stage boundary: field split, subnormals flushed to a zero significand.
      ST_UNPACK: begin
        s_d     = t_q[P-1];
        nz_d    = (e_u != '0) || (m_u != '0);
        nan_d   = (e_u == '1) && (m_u != '0);
        inf_d   = (e_u == '1) && (m_u == '0);
        sig_d   = ((e_u == '0) || (e_u == '1)) ? '0 : {1'b1, m_u};
        sh_d    = $signed({2'b00, e_u}) + SH_OFS;
        state_d = ST_ALIGN;
      end
      // Stage boundary: barrel-shift result captured.
      ST_ALIGN: begin
        mag_d   = {1'b0, al_mag};
        grd_d   = al_grd;
        stk_d   = al_stk;
        ovf_d   = al_ovf;
        state_d = ST_ROUND;
      end
      // Stage boundary: rounded magnitude captured.
      ST_ROUND: begin
        mag_d   = round_mag(mag_q[W:0], grd_q, stk_q, rnd_q);
        state_d = ST_PACK;
      end
      // Stage boundary: signed, saturated result and flags captured.
      ST_PACK: begin
        if (nan_q) begin
          {of_d, res_d} = {1'b1, SAT_POS};
          uf_d          = 1'b0;
        end else begin
          {of_d, res_d} = sat_pack(s_q, mag_q, inf_q | ovf_q);
          uf_d          = nz_q & ~(inf_q | ovf_q) & (mag_q == '0);
        end
        state_d = ST_DONE;
      end
      // First DONE cycle raises ACK; leave only once ACK is seen with Begin low.
      ST_DONE: begin
        if (ack_q && !Begin_FSM) begin
          ack_d   = 1'b0;
          state_d = ST_IDLE;
        end else begin
          ack_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      t_q     <= '0;
      rnd_q   <= 1'b0;
      s_q     <= 1'b0;
      nz_q    <= 1'b0;
      nan_q   <= 1'b0;
      inf_q   <= 1'b0;
      sig_q   <= '0;
      sh_q    <= '0;
      mag_q   <= '0;
      grd_q   <= 1'b0;
      stk_q   <= 1'b0;
      ovf_q   <= 1'b0;
      res_q   <= '0;
      of_q    <= 1'b0;
      uf_q    <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      rnd_q   <= rnd_d;
      s_q     <= s_d;
      nz_q    <= nz_d;
      nan_q   <= nan_d;
      inf_q   <= inf_d;
      sig_q   <= sig_d;
      sh_q    <= sh_d;
      mag_q   <= mag_d;
      grd_q   <= grd_d;
      stk_q   <= stk_d;
      ovf_q   <= ovf_d;
      res_q   <= res_d;
      of_q    <= of_d;
      uf_q    <= uf_d;
      ack_q   <= ack_d;
    end
  end

  assign ACK    = ack_q;
  assign O_F    = of_q;
  assign U_F    = uf_q;
  assign RESULT = res_q;

endmodule

// File: tb/tb_float_to_fixed_conv.sv
// Scoreboard bench for float_to_fixed_conv: a single-precision instance
// (W=32, FRAC=16) and a double-precision instance (W=48, FRAC=24).
module tb_float_to_fixed_conv;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        beg32, rnd32, ack32, of32, uf32;
  logic [31:0] t32, res32;
  logic        beg64, rnd64, ack64, of64, uf64;
  logic [63:0] t64;
  logic [47:0] res64;

  float_to_fixed_conv #(.P(32), .W(32), .FRAC(16)) dut32 (
    .CLK(clk), .RST(rst), .Begin_FSM(beg32), .T(t32), .RND(rnd32),
    .ACK(ack32), .O_F(of32), .U_F(uf32), .RESULT(res32));

  float_to_fixed_conv #(.P(64), .W(48), .FRAC(24)) dut64 (
    .CLK(clk), .RST(rst), .Begin_FSM(beg64), .T(t64), .RND(rnd64),
    .ACK(ack64), .O_F(of64), .U_F(uf64), .RESULT(res64));

  typedef struct {
    logic [63:0] res;
    bit          of;
    bit          uf;
    int          acc;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rise32 = 0, rise64 = 0;
  bit prev32 = 0, prev64 = 0;
  logic [31:0] hold32;
  logic [47:0] hold64;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: real-valued scaling, floor, then nearest-even tie rule.
  function automatic void model(input int p, input int w, input int frac, input logic [63:0] t,
                                input bit rnd, output logic [63:0] res, output bit of,
                                output bit uf);
    int ew, mw, bs, e;
    bit s;
    longint unsigned m;
    longint pos, mag;
    logic [63:0] mask;
    real v, fl, fr, lim;
    ew   = (p == 64) ? 11 : 8;
    mw   = (p == 64) ? 52 : 23;
    bs   = (p == 64) ? 1023 : 127;
    s    = t[p-1];
    e    = int'((t >> mw) & ((64'd1 << ew) - 1));
    m    = t & ((64'd1 << mw) - 1);
    mask = (64'd1 << w) - 1;
    pos  = (64'sd1 <<< (w - 1)) - 1;
    res  = '0;
    of   = 0;
    uf   = 0;
    if (e == (1 << ew) - 1) begin
      of  = 1;
      res = ((m != 0) || !s) ? pos : pos + 1;
      res = res & mask;
      return;
    end
    if (e == 0) begin
      uf = (m != 0);
      return;
    end
    v  = (1.0 + real'(m) / (2.0 ** mw)) * (2.0 ** (e - bs + frac));
    fl = $floor(v);
    fr = v - fl;
    if (rnd && ((fr > 0.5) || ((fr == 0.5) && ((fl / 2.0 - $floor(fl / 2.0)) != 0.0))))
      fl = fl + 1.0;
    lim = s ? (2.0 ** (w - 1)) : (2.0 ** (w - 1)) - 1.0;
    if (fl > lim) begin
      of  = 1;
      res = (s ? pos + 1 : pos) & mask;
      return;
    end
    mag = longint'(fl);
    res = (s ? -mag : mag) & mask;
    uf  = (mag == 0);
  endfunction

  function automatic logic [31:0] gen32();
    int r;
    logic [7:0] e;
    r = $urandom_range(0, 9);
    if (r == 0) return $urandom;
    e = (r == 1) ? 8'hFF : (r == 2) ? 8'h00 : 8'(97 + $urandom_range(0, 50));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  function automatic logic [63:0] gen64();
    int r;
    logic [10:0] e;
    r = $urandom_range(0, 9);
    if (r == 0) return {$urandom, $urandom};
    e = (r == 1) ? 11'h7FF : (r == 2) ? 11'h000 : 11'(983 + $urandom_range(0, 70));
    return {1'($urandom), e, 20'($urandom), $urandom};
  endfunction

  // Issue one conversion, push its expectation, scramble inputs after
  // acceptance, hold Begin for hb edges, then wait for the handshake to end.
  task automatic issue(input bit d64, input logic [63:0] t, input bit rnd,
                       input logic [63:0] er, input bit eo, input bit eu, input int hb);
    exp_t x;
    int r0, n;
    r0 = d64 ? rise64 : rise32;
    @(negedge clk);
    if (d64) begin beg64 = 1; t64 = t; rnd64 = rnd; end
    else     begin beg32 = 1; t32 = t[31:0]; rnd32 = rnd; end
    @(posedge clk);
    @(negedge clk);
    x.res = er; x.of = eo; x.uf = eu; x.acc = cyc;
    if (d64) q64.push_back(x); else q32.push_back(x);
    if (d64) begin t64 = {$urandom, $urandom}; rnd64 = ~rnd; end
    else     begin t32 = $urandom; rnd32 = ~rnd; end
    repeat (hb - 1) @(negedge clk);
    if (d64) beg64 = 0; else beg32 = 0;
    n = 0;
    while (n < 60 && !(((d64 ? rise64 : rise32) > r0) && !(d64 ? ack64 : ack32))) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      total++;
      bad++;
      $display("FAIL handshake_timeout: t=0x%0h got no completed ACK, required one", t);
    end
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (ack32 && !prev32) begin
      rise32++;
      if (q32.size() == 0) begin
        total++; bad++;
        $display("FAIL ack32_unexpected: got ACK=1 required no ACK");
      end else begin
        x = q32.pop_front();
        check("res32", {32'b0, res32}, x.res);
        check("of32", 64'(of32), 64'(x.of));
        check("uf32", 64'(uf32), 64'(x.uf));
        check("lat32", 64'(cyc - x.acc), 64'd5);
        hold32 = res32;
      end
    end else if (ack32 && prev32) begin
      check("hold32", {32'b0, res32}, {32'b0, hold32});
    end
    prev32 = ack32;
    if (ack64 && !prev64) begin
      rise64++;
      if (q64.size() == 0) begin
        total++; bad++;
        $display("FAIL ack64_unexpected: got ACK=1 required no ACK");
      end else begin
        x = q64.pop_front();
        check("res64", {16'b0, res64}, x.res);
        check("of64", 64'(of64), 64'(x.of));
        check("uf64", 64'(uf64), 64'(x.uf));
        check("lat64", 64'(cyc - x.acc), 64'd5);
        hold64 = res64;
      end
    end else if (ack64 && prev64) begin
      check("hold64", {16'b0, res64}, {16'b0, hold64});
    end
    prev64 = ack64;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] t, er;
    bit rnd, eo, eu, seen;
    int r;
    beg32 = 0; beg64 = 0; t32 = '0; t64 = '0; rnd32 = 0; rnd64 = 0;
    repeat (3) @(negedge clk);
    check("rst_ack32", 64'(ack32), 64'd0);
    check("rst_res32", {32'b0, res32}, 64'd0);
    check("rst_of32", 64'(of32), 64'd0);
    check("rst_uf32", 64'(uf32), 64'd0);
    check("rst_ack64", 64'(ack64), 64'd0);
    check("rst_res64", {16'b0, res64}, 64'd0);
    rst = 0;

    issue(0, 64'h3F800000, 0, 64'h00010000, 0, 0, 1);
    issue(0, 64'hC0200000, 0, 64'hFFFD8000, 0, 0, 2);
    issue(0, 64'h37C00000, 0, 64'h00000001, 0, 0, 1);
    issue(0, 64'h37C00000, 1, 64'h00000002, 0, 0, 1);
    issue(0, 64'h38200000, 1, 64'h00000002, 0, 0, 3);
    issue(0, 64'h47800000, 0, 64'h7FFFFFFF, 1, 0, 1);
    issue(0, 64'hC7800000, 0, 64'h80000000, 1, 0, 1);
    issue(0, 64'h7FC00000, 0, 64'h7FFFFFFF, 1, 0, 1);
    issue(0, 64'hFF800000, 1, 64'h80000000, 1, 0, 1);
    issue(0, 64'h358637BD, 0, 64'h00000000, 0, 1, 1);
    issue(0, 64'h358637BD, 1, 64'h00000000, 0, 1, 1);
    issue(0, 64'h80000000, 1, 64'h00000000, 0, 0, 1);

    r = rise32;
    issue(0, 64'h3F800000, 0, 64'h00010000, 0, 0, 20);
    repeat (10) @(negedge clk);
    check("one_ack_held_begin", 64'(rise32), 64'(r + 1));

    issue(0, 64'hC0200000, 0, 64'hFFFD8000, 0, 0, 1);
    @(negedge clk);
    beg32 = 1; t32 = 32'h3F800000; rnd32 = 0;
    @(negedge clk);
    beg32 = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (ack32) seen = 1;
    end
    check("abort_ack", 64'(seen), 64'd0);
    check("abort_res", {32'b0, res32}, 64'd0);
    check("abort_of", 64'(of32), 64'd0);
    check("abort_uf", 64'(uf32), 64'd0);

    for (int i = 0; i < 60; i++) begin
      t = {32'b0, gen32()};
      rnd = 1'($urandom);
      model(32, 32, 16, t, rnd, er, eo, eu);
      issue(0, t, rnd, er, eo, eu, $urandom_range(1, 8));
    end

    issue(1, 64'h3FF8000000000000, 0, 64'h000001800000, 0, 0, 1);
    for (int i = 0; i < 25; i++) begin
      t = gen64();
      rnd = 1'($urandom);
      model(64, 48, 24, t, rnd, er, eo, eu);
      issue(1, t, rnd, er, eo, eu, $urandom_range(1, 8));
    end

    repeat (5) @(negedge clk);
    check("q32_drained", 64'(q32.size()), 64'd0);
    check("q64_drained", 64'(q64.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
